life_row_stream: RTL

Streaming Game-of-Life generation engine. It accepts a board one row per transfer over a valid/ready input and keeps a two-row window. For each interior row it drives the single-cell next-state logic for every column and emits the next-generation row over a valid/ready output. It sits directly upstream of the per-cell logic: it builds every cell's me/n/ne/e/se/s/sw/w/nw inputs and collects the is_alive results into rows.

---
 rtl/life_row_stream_pkg.sv | 19 +
 rtl/life_row_stream_if.sv | 31 +++
 rtl/life_row_next.sv | 36 +++
 rtl/single_cell_boolean_logic.sv | 22 ++
 rtl/life_row_stream.sv | 117 +++++++++++
 5 files changed

// File: rtl/life_row_stream_pkg.sv
// life_pkg: shared types and helpers for the streaming Game-of-Life engine.
//   state_e    : frame FSM states (FILL, STREAM, FLUSH)
//   ROW_IDX_W  : width of a row index for a given frame height (min 1)
//   DEAD_CELL  : value read for any neighbour outside the board
package life_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    function automatic int ROW_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam logic DEAD_CELL = 1'b0;

endpackage

// File: rtl/life_row_stream_if.sv
// life_row_stream_if: row-in / row-out valid-ready bus of the life engine.
//   in_valid/in_ready/in_row                         : current-generation rows
//   out_valid/out_ready/out_row/out_row_idx/out_last : next-generation rows
// slave modport is the engine side, master modport is the producer/consumer side.
interface life_row_stream_if
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) ();
    localparam int IDX_W = ROW_IDX_W(HEIGHT);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_row;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_row;
    logic [IDX_W-1:0] out_row_idx;
    logic             out_last;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, out_last
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, out_last
    );
endinterface

// File: rtl/life_row_next.sv
// life_row_next: combinational next-generation row from a three-row window.
//   above : row r-1 (north), cur : row r, below : row r+1 (south)
//   next  : next-generation row r; bit i is column i, w is column i-1
module life_row_next
    import life_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] next
);
    // Pad one dead cell on each side: pad[i+1] is column i, so for cell i
    // pad[i] is west, pad[i+1] is the column itself and pad[i+2] is east.
    logic [WIDTH+1:0] a_pad, c_pad, b_pad;

    assign a_pad = {DEAD_CELL, above, DEAD_CELL};
    assign c_pad = {DEAD_CELL, cur,   DEAD_CELL};
    assign b_pad = {DEAD_CELL, below, DEAD_CELL};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        single_cell_boolean_logic u_cell (
            .me       (c_pad[i+1]),
            .n        (a_pad[i+1]),
            .ne       (a_pad[i+2]),
            .e        (c_pad[i+2]),
            .se       (b_pad[i+2]),
            .s        (b_pad[i+1]),
            .sw       (b_pad[i]),
            .w        (c_pad[i]),
            .nw       (a_pad[i]),
            .is_alive (next[i])
        );
    end
endmodule

// File: rtl/single_cell_boolean_logic.sv
// single_cell_boolean_logic: Conway next state of one cell.
//   me                         : current state of the cell
//   n/ne/e/se/s/sw/w/nw        : the eight neighbours
//   is_alive                   : next-generation state
module single_cell_boolean_logic (
    input  logic me,
    input  logic n,
    input  logic ne,
    input  logic e,
    input  logic se,
    input  logic s,
    input  logic sw,
    input  logic w,
    input  logic nw,
    output logic is_alive
);
    logic [3:0] cnt;

    assign cnt = 4'(n) + 4'(ne) + 4'(e) + 4'(se) + 4'(s) + 4'(sw) + 4'(w) + 4'(nw);
    // Birth on exactly 3, survival on 2 or 3.
    assign is_alive = (cnt == 4'd3) || (me && cnt == 4'd2);
endmodule

// File: rtl/life_row_stream.sv
// life_row_stream: streaming Game-of-Life generation engine.
//   clk, rst : clock, synchronous active-high reset
//   bus      : life_row_stream_if.slave; rows in, next-generation rows out
//              with out_row_idx and out_last marking row HEIGHT-1.
// Keeps prev/cur rows; each accepted row k>=1 completes output row k-1, and a
// single FLUSH cycle emits the last row with a dead row below it.
module life_row_stream
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic            clk,
    input  logic            rst,
    life_row_stream_if.slave bus
);
    localparam int IDX_W = ROW_IDX_W(HEIGHT);
    localparam int CNT_W = $clog2(HEIGHT + 1);

    if (HEIGHT < 2) begin : g_bad_height
        $error("life_row_stream: HEIGHT must be >= 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_row, cur_row, below_row, next_row;
    logic [CNT_W-1:0] in_cnt;
    logic             slot_free, in_acc, out_acc, out_load, last_in;

    logic             out_valid_q, out_last_q;
    logic [WIDTH-1:0] out_row_q;
    logic [IDX_W-1:0] out_idx_q;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !rst && (state_q != FLUSH) && slot_free;
    assign in_acc       = bus.in_valid && bus.in_ready;
    assign out_acc      = out_valid_q && bus.out_ready;
    assign last_in      = (in_cnt == CNT_W'(HEIGHT - 1));
    // Below the last row the board is dead.
    assign below_row    = (state_q == FLUSH) ? '0 : bus.in_row;

    life_row_next #(.WIDTH(WIDTH)) u_next (
        .above (prev_row),
        .cur   (cur_row),
        .below (below_row),
        .next  (next_row)
    );

    always_comb begin
        state_d  = state_q;
        out_load = 1'b0;
        case (state_q)
            FILL:   if (in_acc) state_d = STREAM;
            STREAM: if (in_acc) begin
                out_load = 1'b1;
                if (last_in) state_d = FLUSH;
            end
            FLUSH:  if (slot_free) begin
                out_load = 1'b1;
                state_d  = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            prev_row <= '0;
            cur_row  <= '0;
            in_cnt   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FILL: if (in_acc) begin
                    prev_row <= '0;
                    cur_row  <= bus.in_row;
                    in_cnt   <= CNT_W'(1);
                end
                STREAM: if (in_acc) begin
                    prev_row <= cur_row;
                    cur_row  <= bus.in_row;
                    in_cnt   <= in_cnt + CNT_W'(1);
                end
                FLUSH: if (slot_free) begin
                    prev_row <= '0;
                    cur_row  <= '0;
                    in_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output register: a load wins over an accept, so a row arriving while
    // the previous one drains keeps out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_row_q   <= next_row;
            out_idx_q   <= (state_q == FLUSH) ? IDX_W'(HEIGHT - 1)
                                              : IDX_W'(in_cnt - CNT_W'(1));
            out_last_q  <= (state_q == FLUSH);
        end else if (out_acc) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_row     = out_row_q;
    assign bus.out_row_idx = out_idx_q;
    assign bus.out_last    = out_last_q;
endmodule
